// File: rtl/spi_disp_pkg.sv
// Shared constants and types for the SPI register dispatcher.
package spi_disp_pkg;

  // Clear command: wipes the sticky ovf/inv flags at frame end.
  localparam logic [7:0] CMD_CLR = 8'hFF;

  // Command byte field positions.
  localparam int TID_MSB = 7;
  localparam int TID_LSB = 5;
  localparam int AI_BIT  = 4;

  // Status byte layout: {ovf, inv, pend, fcnt[4:0]}.
  localparam int ST_OVF  = 7;
  localparam int ST_INV  = 6;
  localparam int ST_PEND = 5;
  localparam int FCNT_W  = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DATA = 1'b1
  } state_t;

  // Queue entry: {tid, ai (carried along, not consumed), offset, data}.
  typedef struct packed {
    logic [2:0] tid;
    logic       ai_unused;
    logic [7:0] offset;
    logic [7:0] data;
  } wr_ent_t;

endpackage

// File: rtl/spi_disp_fifo.sv
// Two-entry write queue. Entry 0 is always the head, so the bus fields
// come straight off a register. Push while full is accepted only when
// the head pops in the same cycle.
module spi_disp_fifo
  import spi_disp_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_push,
  input  wr_ent_t i_din,
  input  logic    i_pop,
  output wr_ent_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  logic [1:0]    r_vld;
  wr_ent_t [1:0] r_mem;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_wpos;

  assign w_pop     = i_pop & r_vld[0];
  assign w_push_ok = i_push & (~r_vld[1] | w_pop);
  // First free slot once any pop this cycle has shifted the queue down.
  assign w_wpos    = w_pop ? r_vld[1] : r_vld[0];

  // Shift on pop, then drop the new entry into the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 2'b00;
      r_mem <= '0;
    end else begin
      if (w_pop) begin
        r_mem[0] <= r_mem[1];
        r_vld    <= {1'b0, r_vld[1]};
      end
      if (w_push_ok) begin
        if (w_wpos) begin
          r_mem[1] <= i_din;
          r_vld[1] <= 1'b1;
        end else begin
          r_mem[0] <= i_din;
          r_vld[0] <= 1'b1;
        end
      end
    end
  end

  assign o_head  = r_mem[0];
  assign o_full  = r_vld[1];
  assign o_empty = ~r_vld[0];

endmodule

// File: rtl/spi_reg_dispatch.sv
// Command decoder and write scheduler on the SPI slave byte bus.
// Frames become offset-addressed register writes queued to N_TGT targets.
module spi_reg_dispatch
  import spi_disp_pkg::*;
#(
  parameter int N_TGT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       addr,
  input  logic [7:0]       data,
  input  logic             first,
  input  logic             last,
  input  logic             strobe,
  output logic [7:0]       out,
  output logic [N_TGT-1:0] bus_sel,
  output logic [7:0]       bus_addr,
  output logic [7:0]       bus_data,
  output logic             bus_valid,
  input  logic [N_TGT-1:0] tgt_ready
);

  localparam logic [3:0] NT = 4'(N_TGT);

  state_t            r_state;
  logic [7:0]        r_off;
  logic              r_ovf;
  logic              r_inv;
  logic [FCNT_W-1:0] r_fcnt;

  logic [2:0]       w_tid;
  logic             w_ai;
  logic             w_clr;
  logic             w_tid_ok;
  logic             w_push;
  logic             w_xfer;
  logic             w_end;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_set;
  logic             w_inv_set;
  logic             w_flag_clr;
  logic             w_ai_unused;
  wr_ent_t          w_ent;
  wr_ent_t          w_head;
  logic [N_TGT-1:0] w_sel;

  assign w_tid    = addr[TID_MSB:TID_LSB];
  assign w_ai     = addr[AI_BIT];
  assign w_clr    = (addr == CMD_CLR);
  assign w_tid_ok = ({1'b0, w_tid} < NT);

  // Only non-first data bytes inside a frame produce writes.
  assign w_push = strobe & ~first & (r_state == S_DATA) & w_tid_ok;
  assign w_ent  = {w_tid, w_ai, r_off, data};
  assign w_end  = strobe & last;

  assign w_xfer     = bus_valid & |(bus_sel & tgt_ready);
  assign w_ovf_set  = w_push & w_full & ~w_xfer;
  // The clear command uses tid 7 on purpose and must not flag itself.
  assign w_inv_set  = strobe & first & ~w_tid_ok & ~w_clr;
  assign w_flag_clr = w_end & w_clr;

  spi_disp_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_ent),
    .i_pop   (w_xfer),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_ai_unused = w_head.ai_unused;

  assign bus_valid = ~w_empty;
  assign bus_addr  = w_head.offset;
  assign bus_data  = w_head.data;

  // One-hot decode of the head target, forced to zero when idle.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_TGT; i++) w_sel[i] = bus_valid && (w_head.tid == 3'(i));
  end
  assign bus_sel = w_sel;

  // Frame FSM, offset counter, frame counter and sticky flags (set wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_off   <= 8'h00;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      if (strobe) begin
        if (first) begin
          r_off   <= data;
          r_state <= last ? S_IDLE : S_DATA;
        end else if (r_state == S_DATA) begin
          if (w_push && w_ai) r_off <= r_off + 8'd1;
          if (last) r_state <= S_IDLE;
        end
      end
      if (w_end) r_fcnt <= r_fcnt + 5'd1;
      r_ovf <= w_ovf_set | (r_ovf & ~w_flag_clr);
      r_inv <= w_inv_set | (r_inv & ~w_flag_clr);
    end
  end

  assign out = {r_ovf, r_inv, ~w_empty, r_fcnt};

endmodule

// File: tb/tb_spi_reg_dispatch.sv
// Bench for spi_reg_dispatch: directed frame table, hand-written corner
// sequences and random frames, all checked against a queue-level model.
module tb_spi_reg_dispatch;

  localparam int N_TGT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       addr = 8'h00;
  logic [7:0]       data = 8'h00;
  logic             first = 1'b0;
  logic             last = 1'b0;
  logic             strobe = 1'b0;
  logic [7:0]       out;
  logic [N_TGT-1:0] bus_sel;
  logic [7:0]       bus_addr;
  logic [7:0]       bus_data;
  logic             bus_valid;
  logic [N_TGT-1:0] tgt_ready = '0;

  always #5 clk = ~clk;

  spi_reg_dispatch #(.N_TGT(N_TGT)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data      (data),
    .first     (first),
    .last      (last),
    .strobe    (strobe),
    .out       (out),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .tgt_ready (tgt_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] tid;
    logic [7:0] off;
    logic [7:0] dat;
  } wr_t;

  typedef struct {
    logic [N_TGT-1:0] sel;
    logic [7:0]       a;
    logic [7:0]       d;
  } log_t;

  wr_t  mq[$];
  log_t dlog[$];
  logic m_ovf = 1'b0;
  logic m_inv = 1'b0;
  int   m_fcnt = 0;
  bit   m_inframe = 1'b0;
  logic [7:0] m_off = 8'h00;
  bit   chk_en = 1'b0;
  bit   rnd_rdy = 1'b0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write queue of depth 2 plus flags, from the rules.
  always @(posedge clk) begin : model
    bit  pop, psh, tok, clr, oset, iset;
    wr_t e;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_inv = 0; m_fcnt = 0; m_inframe = 0; m_off = 8'h00;
    end else begin
      tok  = (int'(addr[7:5]) < N_TGT);
      clr  = (addr == 8'hFF);
      pop  = (mq.size() > 0) && tgt_ready[int'(mq[0].tid)];
      psh  = 0; iset = 0;
      e    = '{3'd0, 8'd0, 8'd0};
      if (strobe) begin
        if (first) begin
          m_off = data;
          m_inframe = !last;
          if (!tok && !clr) iset = 1;
        end else begin
          if (m_inframe && tok) begin
            e = '{addr[7:5], m_off, data};
            psh = 1;
            if (addr[4]) m_off = m_off + 8'd1;
          end
          if (last) m_inframe = 0;
        end
      end
      oset = psh && (mq.size() == 2) && !pop;
      if (pop) void'(mq.pop_front());
      if (psh && !oset) mq.push_back(e);
      if (strobe && last) begin
        m_fcnt = (m_fcnt + 1) % 32;
        if (clr) begin m_ovf = 0; m_inv = 0; end
      end
      if (oset) m_ovf = 1;
      if (iset) m_inv = 1;
    end
  end

  // Per-cycle check against the model, plus a log of completed transfers.
  always @(negedge clk) begin
    logic [N_TGT-1:0] es;
    if (chk_en) begin
      cmp("bus_valid", bus_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        es = N_TGT'(1) << mq[0].tid;
        cmp("bus_word", {bus_sel, bus_addr, bus_data}, {es, mq[0].off, mq[0].dat});
      end else begin
        cmp("bus_sel_idle", bus_sel, '0);
      end
      cmp("status", out, {m_ovf, m_inv, (mq.size() > 0), 5'(m_fcnt)});
    end
    if (!rst && bus_valid && |(bus_sel & tgt_ready))
      dlog.push_back('{bus_sel, bus_addr, bus_data});
  end

  // Random ready pattern during the random phase.
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      tgt_ready = N_TGT'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    strobe = 0; first = 0; last = 0;
    repeat (n) tick();
  endtask

  task automatic sbyte(logic f, logic l, logic [7:0] d);
    strobe = 1; first = f; last = l; data = d;
    tick();
    strobe = 0; first = 0; last = 0;
  endtask

  task automatic frame(logic [7:0] c, int n, logic [0:4][7:0] b);
    addr = c;
    for (int j = 0; j < n; j++) sbyte(j == 0, j == n - 1, b[j]);
  endtask

  typedef struct {
    logic [7:0]       cmd;
    int               n;
    logic [0:4][7:0]  b;
    int               nwr;
    logic [N_TGT-1:0] sel;
    logic [7:0]       a0, d0, a1, d1;
    logic [7:0]       st;
  } vec_t;

  vec_t tv[5];

  initial begin
    tv[0] = '{8'h30, 3, {8'h10, 8'hAB, 8'hCD, 8'h00, 8'h00}, 2, 4'b0010,
              8'h10, 8'hAB, 8'h11, 8'hCD, 8'h01};
    tv[1] = '{8'h40, 4, {8'hFF, 8'h01, 8'h02, 8'h03, 8'h00}, 3, 4'b0100,
              8'hFF, 8'h01, 8'hFF, 8'h03, 8'h02};
    tv[2] = '{8'h10, 3, {8'hFF, 8'h0A, 8'h0B, 8'h00, 8'h00}, 2, 4'b0001,
              8'hFF, 8'h0A, 8'h00, 8'h0B, 8'h03};
    tv[3] = '{8'hA0, 4, {8'h00, 8'h11, 8'h22, 8'h33, 8'h00}, 0, 4'b0000,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h44};
    tv[4] = '{8'hFF, 4, {8'h00, 8'h11, 8'h22, 8'h33, 8'h00}, 0, 4'b0000,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h05};

    // Reset state.
    repeat (3) tick();
    chk_en = 1;
    @(negedge clk);
    cmp("rst_out", out, 8'h00);
    cmp("rst_bus", {bus_valid, bus_sel, bus_addr, bus_data}, '0);
    tick();
    rst = 0;
    tick();

    // Directed frame table.
    tgt_ready = '1;
    for (int i = 0; i < 5; i++) begin
      dlog.delete();
      frame(tv[i].cmd, tv[i].n, tv[i].b);
      idle(4);
      cmp("tbl_nwr", dlog.size(), tv[i].nwr);
      if (tv[i].nwr > 0 && dlog.size() > 0) begin
        cmp("tbl_first", {dlog[0].sel, dlog[0].a, dlog[0].d}, {tv[i].sel, tv[i].a0, tv[i].d0});
        cmp("tbl_last", {dlog[$].sel, dlog[$].a, dlog[$].d}, {tv[i].sel, tv[i].a1, tv[i].d1});
      end
      cmp("tbl_status", out, tv[i].st);
    end

    // Backpressure and overflow: only two of five writes survive.
    dlog.delete();
    tgt_ready = '0;
    addr = 8'h20;
    sbyte(1, 0, 8'h05);
    sbyte(0, 0, 8'hD1);
    sbyte(0, 0, 8'hD2);
    sbyte(0, 0, 8'hD3);
    sbyte(0, 0, 8'hD4);
    sbyte(0, 1, 8'hD5);
    idle(2);
    @(negedge clk);
    cmp("bp_hold", {bus_valid, bus_sel, bus_addr, bus_data}, {1'b1, 4'b0010, 8'h05, 8'hD1});
    cmp("bp_status", out, 8'hA6);
    tick();
    tgt_ready = '1;
    idle(4);
    cmp("bp_drain_n", dlog.size(), 2);
    if (dlog.size() >= 2) cmp("bp_drain_d", {dlog[0].d, dlog[1].d}, {8'hD1, 8'hD2});
    addr = 8'hFF;
    sbyte(1, 1, 8'h00);
    idle(1);
    @(negedge clk);
    cmp("clr_status", out, 8'h07);
    tick();

    // Reset mid-frame with one write queued.
    dlog.delete();
    tgt_ready = '0;
    addr = 8'h30;
    sbyte(1, 0, 8'h20);
    sbyte(0, 0, 8'h77);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    cmp("mid_rst_valid", bus_valid, 1'b0);
    cmp("mid_rst_out", out, 8'h00);
    tick();
    tgt_ready = '1;
    sbyte(0, 0, 8'h99);
    idle(3);
    cmp("mid_rst_nowr", dlog.size(), 0);

    // Random frames, random gaps, random ready.
    rnd_rdy = 1;
    for (int f = 0; f < 250; f++) begin
      logic [7:0] c;
      int n;
      case ($urandom % 8)
        0, 1, 2, 3, 4: c = {3'($urandom % 4), 1'($urandom), 4'($urandom)};
        5, 6:          c = {3'(4 + $urandom % 4), 1'($urandom), 4'($urandom)};
        default:       c = 8'hFF;
      endcase
      if ($urandom % 8 == 0) sbyte(0, 1'($urandom), 8'($urandom));
      n = 1 + $urandom % 5;
      addr = c;
      for (int j = 0; j < n; j++) begin
        sbyte((j == 0) || ($urandom % 12 == 0), j == n - 1, 8'($urandom));
        if ($urandom % 3 == 0) idle(1 + $urandom % 2);
      end
      idle($urandom % 3);
    end
    rnd_rdy = 0;
    tick();
    tgt_ready = '1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
